// File: rtl/uart_tx_fifo.sv
// Byte-FIFO-fed 8N1 UART transmitter: queued bytes go out LSB first,
// back-to-back with no idle gap while the FIFO holds data.
module uart_tx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned CW           = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic          busy,
    output logic          tx
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state;
    logic [BW-1:0]   baud;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic            avail;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    logic            bit_end_c;
    logic            pop_c;
    logic            push_c;
    logic [CW-1:0]   count_next_c;

    // IDLE acts on a one-cycle-delayed view of empty; STOP chains on the live flag
    assign bit_end_c    = (baud == BAUD_LAST);
    assign pop_c        = !empty && (((state == IDLE) && avail) ||
                                     ((state == STOP) && bit_end_c));
    assign push_c       = wr_en && (!full || pop_c);
    assign count_next_c = count + CW'(push_c) - CW'(pop_c);

    // FIFO bookkeeping; flags reflect the post-edge contents
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + AW'(1);
            if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next_c;
            empty <= (count_next_c == '0);
            full  <= (count_next_c == DEPTH_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) mem[wr_ptr] <= wr_data;
    end

    // Frame sequencer; tx and busy come straight from flops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            tx      <= 1'b1;
            busy    <= 1'b0;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            avail   <= 1'b0;
        end else begin
            avail <= !empty;
            case (state)
                IDLE: begin
                    if (pop_c) begin
                        state <= START;
                        tx    <= 1'b0;
                        busy  <= 1'b1;
                        baud  <= '0;
                        shift <= mem[rd_ptr];
                    end
                end
                START: begin
                    if (bit_end_c) begin
                        state   <= DATA;
                        baud    <= '0;
                        bit_idx <= '0;
                        tx      <= shift[0];
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                DATA: begin
                    if (bit_end_c) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= {1'b0, shift[7:1]};
                            tx      <= shift[1];
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                STOP: begin
                    if (bit_end_c) begin
                        baud <= '0;
                        if (pop_c) begin
                            state <= START;
                            tx    <= 1'b0;
                            shift <= mem[rd_ptr];
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo (4 clocks/bit, 4-deep FIFO) with a
// serial-line monitor that decodes frames and records their start cycles.
module tb_uart_tx_fifo;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [2:0] count;
    logic       busy;
    logic       tx;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int push_edge = 0;

    logic       mon_en = 1'b0;
    logic [7:0] rx_q[$];
    int         start_q[$];

    uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .CW(3)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .count(count), .busy(busy), .tx(tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // settle point: just after the falling edge, after the monitor has run
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        wr_en     = 1'b1;
        wr_data   = b;
        push_edge = cyc + 1;
        tick();
        wr_en     = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        check("frame_count", 32'(rx_q.size()), 32'(n));
    endtask

    task automatic clear_log();
        rx_q.delete();
        start_q.delete();
    endtask

    // line monitor: 40 samples per frame, each bit must hold for 4 cycles
    initial begin
        int         m_s = 0;
        logic       m_act = 1'b0;
        logic       m_bad = 1'b0;
        logic       m_bitv = 1'b1;
        logic       m_start = 1'b0;
        logic       m_stop = 1'b1;
        logic [7:0] m_data = '0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                m_act = 1'b0;
            end else if (!m_act) begin
                if (tx === 1'b0) begin
                    m_act = 1'b1;
                    m_s   = 0;
                    m_bad = 1'b0;
                    start_q.push_back(cyc);
                end
            end else begin
                m_s++;
            end
            if (m_act) begin
                if (m_s % 4 == 0) m_bitv = tx;
                else if (tx !== m_bitv) m_bad = 1'b1;
                if (m_s % 4 == 3) begin
                    if (m_s / 4 == 0)      m_start = m_bitv;
                    else if (m_s / 4 <= 8) m_data[3'(m_s / 4 - 1)] = m_bitv;
                    else                   m_stop = m_bitv;
                end
                if (m_s == 39) begin
                    rx_q.push_back(m_data);
                    check("start_bit", 32'(m_start), 32'd0);
                    check("stop_bit", 32'(m_stop), 32'd1);
                    check("bit_hold", 32'(m_bad), 32'd0);
                    m_act = 1'b0;
                end
            end
        end
    end

    initial begin
        int lows;
        int s0;
        int k;
        reset   = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        repeat (3) tick();
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        reset = 1'b1;
        tick();

        // reset mid-frame aborts asynchronously and leaves the line quiet
        push_byte(8'hA5);
        repeat (15) tick();
        check("t1_busy_pre", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("t1_tx_async", 32'(tx), 32'd1);
        check("t1_busy_async", 32'(busy), 32'd0);
        check("t1_count_async", 32'(count), 32'd0);
        check("t1_empty_async", 32'(empty), 32'd1);
        tick();
        reset = 1'b1;
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (tx !== 1'b1) lows++;
        end
        check("t1_quiet_line", 32'(lows), 32'd0);
        check("t1_busy_after", 32'(busy), 32'd0);
        mon_en = 1'b1;

        // single byte: latency, bits, frame length
        clear_log();
        push_byte(8'h55);
        wait_frames(1, 100);
        check("t2_start_latency", 32'(start_q[0] - push_edge), 32'd2);
        check("t2_byte", 32'(rx_q[0]), 32'h55);
        check("t2_busy_in_stop", 32'(busy), 32'd1);
        tick();
        check("t2_busy_drop", 32'(busy), 32'd0);
        check("t2_frame_len", 32'(cyc - start_q[0]), 32'd40);
        check("t2_empty", 32'(empty), 32'd1);

        // three consecutive pushes: back-to-back frames
        clear_log();
        push_byte(8'h01);
        push_byte(8'h02);
        push_byte(8'h03);
        wait_frames(3, 200);
        check("t3_byte0", 32'(rx_q[0]), 32'h01);
        check("t3_byte1", 32'(rx_q[1]), 32'h02);
        check("t3_byte2", 32'(rx_q[2]), 32'h03);
        check("t3_gap01", 32'(start_q[1] - start_q[0]), 32'd40);
        check("t3_gap12", 32'(start_q[2] - start_q[1]), 32'd40);
        tick();
        check("t3_total", 32'(cyc - start_q[0]), 32'd120);
        check("t3_busy_end", 32'(busy), 32'd0);

        // overflow: sixth byte dropped
        clear_log();
        for (int i = 0; i < 6; i++) push_byte(8'hA1 + 8'(i));
        check("t4_count", 32'(count), 32'd4);
        check("t4_full", 32'(full), 32'd1);
        wait_frames(5, 300);
        repeat (60) tick();
        check("t4_no_sixth", 32'(rx_q.size()), 32'd5);
        for (int i = 0; i < 5; i++) check("t4_byte", 32'(rx_q[i]), 32'(8'hA1 + 8'(i)));
        check("t4_empty", 32'(empty), 32'd1);
        check("t4_busy", 32'(busy), 32'd0);

        // push while full in the same cycle as the FSM pop
        clear_log();
        for (int i = 0; i < 5; i++) push_byte(8'hB0 + 8'(i));
        check("t5_full_pre", 32'(full), 32'd1);
        check("t5_count_pre", 32'(count), 32'd4);
        check("t5_started", 32'(start_q.size()), 32'd1);
        s0 = (start_q.size() > 0) ? start_q[0] : cyc;
        k = 0;
        while (cyc < s0 + 39 && k < 100) begin
            tick();
            k++;
        end
        check("t5_align", 32'(cyc - s0), 32'd39);
        push_byte(8'hB5);
        check("t5_count_post", 32'(count), 32'd4);
        check("t5_full_post", 32'(full), 32'd1);
        wait_frames(6, 400);
        for (int i = 0; i < 6; i++) check("t5_byte", 32'(rx_q[i]), 32'(8'hB0 + 8'(i)));
        check("t5_gap", 32'(start_q[1] - start_q[0]), 32'd40);

        // pointer wrap: 20 bytes paced on full
        clear_log();
        for (int i = 0; i < 20; i++) begin
            k = 0;
            while (full && k < 200) begin
                tick();
                k++;
            end
            push_byte(8'(i));
        end
        wait_frames(20, 1500);
        for (int i = 0; i < 20; i++) check("t6_byte", 32'(rx_q[i]), 32'(i));
        k = 0;
        while (busy && k < 100) begin
            tick();
            k++;
        end
        check("t6_busy_end", 32'(busy), 32'd0);
        check("t6_empty_end", 32'(empty), 32'd1);
        check("t6_count_end", 32'(count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
